// File: rtl/interleaver_cycle_ctrl.sv
// rtl/interleaver_cycle_ctrl.sv - per-sample cycle sequencer and sweepstart config store for interleaver_set
// Optional abort/abort_ack handshake: define INTERLEAVER_CTRL_ABORT_EN.
module interleaver_cycle_ctrl #(
  parameter  int p   = 32,
  parameter  int fo  = 2,
  parameter  int z   = 8,
  parameter  int ec  = 2,
  localparam int NC  = p * fo / z,
  localparam int CPC = NC + ec,
  localparam int LPZ = (p == z) ? 1 : $clog2(p / z),
  localparam int CIW = $clog2(CPC),
  localparam int EIW = $clog2(NC),
  localparam int SW  = (fo > 1) ? $clog2(fo) : 1,
  localparam int FZ  = fo * z,
  localparam int AW  = $clog2(fo * z)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
`ifdef INTERLEAVER_CTRL_ABORT_EN
  input  logic             abort,
  output logic             abort_ack,
`endif
  output logic             ready,
  output logic             busy,
  output logic [CIW-1:0]   cycle_index,
  output logic [EIW-1:0]   eff_cycle_index,
  output logic             idx_valid,
  output logic [SW-1:0]    sweep,
  output logic             done,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [LPZ-1:0]   cfg_data,
  output logic             cfg_err,
  output logic [LPZ*FZ-1:0] sweepstart_flat
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_EXTRA = 2'd2
  } state_t;

  localparam logic [CIW-1:0] LAST_CYC = CIW'(CPC - 1);
  localparam logic [CIW-1:0] LAST_RUN = CIW'(NC - 1);
  // With p==z every eff index bit is a sweep bit.
  localparam int SLO = (p == z) ? 0 : LPZ;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CIW-1:0]   r_cycle;
  logic [CIW-1:0]   w_cycle_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_cfg_err;
  logic             w_cfg_ok;
  logic             w_abort;
  logic [LPZ-1:0]   r_ss [FZ];

`ifdef INTERLEAVER_CTRL_ABORT_EN
  logic             r_abort_ack;
  assign w_abort   = abort;
  assign abort_ack = r_abort_ack;
`else
  assign w_abort   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cycle <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cycle <= w_cycle_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Abort outranks both stall and pass end; start is only seen in IDLE or on the final advancing cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cycle_nxt = r_cycle;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_cycle_nxt = '0;
        end
      end
      S_RUN, S_EXTRA: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_cycle_nxt = '0;
        end else if (!stall) begin
          if (r_cycle == LAST_CYC) begin
            w_done_nxt  = 1'b1;
            w_cycle_nxt = '0;
            w_state_nxt = start ? S_RUN : S_IDLE;
          end else begin
            w_cycle_nxt = r_cycle + CIW'(1);
            if (r_state == S_RUN && r_cycle == LAST_RUN) begin
              w_state_nxt = S_EXTRA;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cycle_nxt = '0;
      end
    endcase
  end

`ifdef INTERLEAVER_CTRL_ABORT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_abort_ack <= 1'b0;
    end else begin
      r_abort_ack <= w_abort && (r_state != S_IDLE);
    end
  end
`endif

  assign w_cfg_ok = cfg_we && (r_state == S_IDLE) && (int'(cfg_addr) < FZ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cfg_err <= 1'b0;
      for (int i = 0; i < FZ; i++) begin
        r_ss[i] <= '0;
      end
    end else begin
      r_cfg_err <= cfg_we && !w_cfg_ok;
      if (w_cfg_ok) begin
        r_ss[cfg_addr] <= cfg_data;
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < FZ; k++) begin : g_flat
      assign sweepstart_flat[k*LPZ +: LPZ] = r_ss[k];
    end
    if (fo > 1) begin : g_sweep
      assign sweep = eff_cycle_index[EIW-1:SLO];
    end else begin : g_nosweep
      assign sweep = '0;
    end
  endgenerate

  assign ready           = (r_state == S_IDLE);
  assign busy            = (r_state != S_IDLE);
  assign idx_valid       = (r_state == S_RUN);
  assign cycle_index     = r_cycle;
  assign eff_cycle_index = r_cycle[EIW-1:0];
  assign done            = r_done;
  assign cfg_err         = r_cfg_err;

endmodule

// File: tb/tb_interleaver_cycle_ctrl.sv
// tb/tb_interleaver_cycle_ctrl.sv - vector table, directed corner sequences and randomized model check
// Abort checks are compiled when INTERLEAVER_CTRL_ABORT_EN is defined.
module tb_interleaver_cycle_ctrl;
  localparam int P = 32, FO = 2, Z = 8, EC = 2;
  localparam int NC = P * FO / Z, CPC = NC + EC;
  localparam int LPZ = 2, CIW = 4, EIW = 3, SW = 1, FZ = FO * Z, AW = 4;
`ifdef INTERLEAVER_CTRL_ABORT_EN
  localparam bit HAS_ABORT = 1'b1;
`else
  localparam bit HAS_ABORT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, stall, cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [LPZ-1:0] cfg_data;
  logic ready, busy, idx_valid, done, cfg_err;
  logic [CIW-1:0] cycle_index;
  logic [EIW-1:0] eff_cycle_index;
  logic [SW-1:0] sweep;
  logic [LPZ*FZ-1:0] sweepstart_flat;
`ifdef INTERLEAVER_CTRL_ABORT_EN
  logic abort, abort_ack;
`endif

  interleaver_cycle_ctrl #(.p(P), .fo(FO), .z(Z), .ec(EC)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
`ifdef INTERLEAVER_CTRL_ABORT_EN
    .abort(abort), .abort_ack(abort_ack),
`endif
    .ready(ready), .busy(busy), .cycle_index(cycle_index),
    .eff_cycle_index(eff_cycle_index), .idx_valid(idx_valid), .sweep(sweep),
    .done(done), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .sweepstart_flat(sweepstart_flat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a pass is the index sequence 0..CPC-1; m_pos is the position shown (-1 = no pass).
  int m_pos;
  bit m_done, m_err, m_ack;
  logic [LPZ-1:0] m_ss [FZ];

  function automatic void m_reset();
    m_pos = -1; m_done = 0; m_err = 0; m_ack = 0;
    for (int i = 0; i < FZ; i++) m_ss[i] = '0;
  endfunction

  function automatic void m_step(bit st, bit sl, bit ab, bit we, int addr, logic [LPZ-1:0] data);
    bit idle;
    idle = (m_pos < 0);
    m_err = we && !(idle && addr < FZ);
    if (we && idle && addr < FZ) m_ss[addr] = data;
    m_done = 0; m_ack = 0;
    if (idle) begin
      if (st) m_pos = 0;
    end else if (ab) begin
      m_pos = -1; m_ack = 1;
    end else if (!sl) begin
      if (m_pos == CPC - 1) begin
        m_done = 1;
        m_pos = st ? 0 : -1;
      end else begin
        m_pos++;
      end
    end
  endfunction

  task automatic model_check();
    int c, e;
    logic [LPZ*FZ-1:0] f;
    c = (m_pos < 0) ? 0 : m_pos;
    e = c % (1 << EIW);
    for (int i = 0; i < FZ; i++) f[i*LPZ +: LPZ] = m_ss[i];
    chk("m_ready", ready, m_pos < 0);
    chk("m_busy", busy, m_pos >= 0);
    chk("m_cycle", cycle_index, c);
    chk("m_eff", eff_cycle_index, e);
    chk("m_valid", idx_valid, (m_pos >= 0) && (m_pos < NC));
    chk("m_sweep", sweep, e / (P / Z));
    chk("m_done", done, m_done);
    chk("m_cfg_err", cfg_err, m_err);
    chk("m_flat", sweepstart_flat, f);
`ifdef INTERLEAVER_CTRL_ABORT_EN
    chk("m_abort_ack", abort_ack, m_ack);
`endif
  endtask

  task automatic drive(input bit st, input bit sl, input bit ab, input bit we,
                       input logic [AW-1:0] a, input logic [LPZ-1:0] d);
    start = st; stall = sl; cfg_we = we; cfg_addr = a; cfg_data = d;
`ifdef INTERLEAVER_CTRL_ABORT_EN
    abort = ab;
`endif
    @(posedge clk);
    m_step(st, sl, ab, we, int'(a), d);
    #1;
  endtask

  task automatic cyc(input bit st, input bit sl, input bit ab, input bit we,
                     input logic [AW-1:0] a, input logic [LPZ-1:0] d);
    drive(st, sl, ab, we, a, d);
    model_check();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (m_pos >= 0 && g < 40) begin
      cyc(0, 0, 0, 0, '0, '0);
      g++;
    end
    chk("drain_bound", g < 40, 1);
  endtask

  typedef struct {
    bit st, sl, we;
    logic [AW-1:0] a;
    logic [LPZ-1:0] d;
    bit rdy;
    int cyc;
    bit vld, swp, dn, err;
  } vec_t;
  vec_t tbl[15];

  initial begin
    int found, e;
    // Basic pass, then idle config write, then a rejected write while busy.
    for (int i = 0; i < 10; i++)
      tbl[i] = '{st: (i == 0), sl: 0, we: 0, a: 0, d: 0, rdy: 0, cyc: i,
                 vld: (i < 8), swp: (i >= 4 && i < 8), dn: 0, err: 0};
    tbl[10] = '{st: 0, sl: 0, we: 0, a: 0, d: 0, rdy: 1, cyc: 0, vld: 0, swp: 0, dn: 1, err: 0};
    tbl[11] = '{st: 0, sl: 0, we: 1, a: 3, d: 2, rdy: 1, cyc: 0, vld: 0, swp: 0, dn: 0, err: 0};
    tbl[12] = '{st: 1, sl: 0, we: 0, a: 0, d: 0, rdy: 0, cyc: 0, vld: 1, swp: 0, dn: 0, err: 0};
    tbl[13] = '{st: 0, sl: 0, we: 1, a: 5, d: 1, rdy: 0, cyc: 1, vld: 1, swp: 0, dn: 0, err: 1};
    tbl[14] = '{st: 0, sl: 0, we: 0, a: 0, d: 0, rdy: 0, cyc: 2, vld: 1, swp: 0, dn: 0, err: 0};

    reset = 1; start = 0; stall = 0; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
`ifdef INTERLEAVER_CTRL_ABORT_EN
    abort = 0;
`endif
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cycle", cycle_index, 0);
    chk("rst_valid", idx_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_flat", sweepstart_flat, 0);
    reset = 0;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].st, tbl[i].sl, 0, tbl[i].we, tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d_ready", i), ready, tbl[i].rdy);
      chk($sformatf("vec%0d_cycle", i), cycle_index, tbl[i].cyc);
      chk($sformatf("vec%0d_valid", i), idx_valid, tbl[i].vld);
      chk($sformatf("vec%0d_sweep", i), sweep, tbl[i].swp);
      chk($sformatf("vec%0d_done", i), done, tbl[i].dn);
      chk($sformatf("vec%0d_cfg_err", i), cfg_err, tbl[i].err);
    end
    chk("cfg_addr3", sweepstart_flat[7:6], 2'b10);
    chk("cfg_addr5_busy", sweepstart_flat[11:10], 2'b00);
    drain();

    // Stall for 3 cycles at index 5 delays done by exactly 3 cycles.
    cyc(1, 0, 0, 0, '0, '0);
    for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 0, '0, '0);
    for (int i = 6; i <= 8; i++) begin
      cyc(0, 1, 0, 0, '0, '0);
      chk("stall_hold", cycle_index, 5);
    end
    e = 8; found = -1;
    while (e < 30 && found < 0) begin
      cyc(0, 0, 0, 0, '0, '0);
      e++;
      if (done) found = e;
    end
    chk("stall_done_edge", found, 13);
    drain();

    // start held high: back-to-back passes, done once at the seam.
    for (int k = 1; k <= 20; k++) begin
      cyc(1, 0, 0, 0, '0, '0);
      chk("b2b_cycle", cycle_index, (k - 1) % CPC);
      chk("b2b_done", done, k == 11);
      chk("b2b_ready", ready, 0);
    end
    drain();

    // Asynchronous reset mid-pass.
    cyc(1, 0, 0, 0, '0, '0);
    for (int i = 1; i <= 6; i++) cyc(0, 0, 0, 0, '0, '0);
    chk("pre_rst_cycle", cycle_index, 6);
    #2 reset = 1;
    #1;
    chk("arst_cycle", cycle_index, 0);
    chk("arst_ready", ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_valid", idx_valid, 0);
    chk("arst_done", done, 0);
    chk("arst_flat", sweepstart_flat, 0);
    m_reset();
    @(posedge clk); @(posedge clk); #2;
    reset = 0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, '0, '0);
    cyc(1, 0, 0, 0, '0, '0);
    e = 0; found = -1;
    while (e < 30 && found < 0) begin
      cyc(0, 0, 0, 0, '0, '0);
      e++;
      if (done) found = e;
    end
    chk("post_rst_done_edge", found, CPC);

`ifdef INTERLEAVER_CTRL_ABORT_EN
    cyc(1, 0, 0, 0, '0, '0);
    for (int i = 1; i <= 9; i++) cyc(0, 0, 0, 0, '0, '0);
    chk("abort_pre_cycle", cycle_index, 9);
    cyc(0, 1, 1, 0, '0, '0);
    chk("abort_ready", ready, 1);
    chk("abort_ack_pulse", abort_ack, 1);
    chk("abort_no_done", done, 0);
    cyc(0, 0, 0, 0, '0, '0);
    chk("abort_ack_clear", abort_ack, 0);
    chk("abort_no_done2", done, 0);
`endif

    // Randomized traffic against the reference.
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom % 4) == 0, ($urandom % 5) == 0,
          HAS_ABORT && (($urandom % 25) == 0),
          ($urandom % 3) == 0, AW'($urandom), LPZ'($urandom));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
